mouse_cursor: RTL

MOUSE_CURSOR -- requirements
Module: mouse_cursor

---
 rtl/mouse_cursor_if.sv | 19 +
 rtl/mouse_cursor.sv | 81 ++++++++
 2 files changed

// File: rtl/mouse_cursor_if.sv
// mouse_cursor_if: PS/2 byte stream in, cursor position and button state out
interface mouse_cursor_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [9:0] CursorX;
    logic [9:0] CursorY;
    logic       left_btn;
    logic       right_btn;
    logic       pkt_done;
    logic       sync_err;
    modport master(
        output byte_in, byte_valid,
        input  CursorX, CursorY, left_btn, right_btn, pkt_done, sync_err
    );
    modport slave(
        input  byte_in, byte_valid,
        output CursorX, CursorY, left_btn, right_btn, pkt_done, sync_err
    );
endinterface

// File: rtl/mouse_cursor.sv
// mouse_cursor: assembles 3-byte PS/2 mouse packets and moves a clamped cursor
module mouse_cursor #(
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int TIMEOUT = 100000
) (
    input logic           Clk,
    input logic           Reset,
    mouse_cursor_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {B0, B1, B2, APPLY} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] idle, idle_nxt;
    logic accept, timeout;
    // byte0 keeps only {yovf, xovf, ysign, xsign, right, left}
    logic [5:0] hdr;
    logic [7:0] dxb, dyb;
    logic signed [11:0] dx, dy, nx, ny;
    logic [9:0] cx, cy;
    logic lb, rb, pd, se;
    always_comb begin
        state_nxt = state;
        idle_nxt = '0;
        accept = 1'b0;
        timeout = 1'b0;
        case (state)
            B0: begin
                accept = bus.byte_valid && bus.byte_in[3];
                state_nxt = accept ? B1 : B0;
            end
            B1, B2: begin
                accept = bus.byte_valid;
                timeout = !accept && idle == CW'(TIMEOUT - 1);
                state_nxt = accept ? (state == B1 ? B2 : APPLY) : timeout ? B0 : state;
                idle_nxt = (accept || timeout) ? '0 : idle + 1'b1;
            end
            default: state_nxt = B0;
        endcase
    end
    assign dx = hdr[4] ? '0 : {{4{hdr[2]}}, dxb};
    assign dy = hdr[5] ? '0 : {{4{hdr[3]}}, dyb};
    assign nx = $signed({2'b00, cx}) + dx;
    assign ny = $signed({2'b00, cy}) - dy;
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= B0;
            idle <= '0;
            cx <= 10'(X_INIT);
            cy <= 10'(Y_INIT);
            lb <= 1'b0;
            rb <= 1'b0;
            pd <= 1'b0;
            se <= 1'b0;
        end else begin
            state <= state_nxt;
            idle <= idle_nxt;
            pd <= state == APPLY;
            se <= (state == B0 && bus.byte_valid && !bus.byte_in[3]) || timeout;
            if (state == APPLY) begin
                cx <= nx < 0 ? '0 : nx > X_MAX ? 10'(X_MAX) : nx[9:0];
                cy <= ny < 0 ? '0 : ny > Y_MAX ? 10'(Y_MAX) : ny[9:0];
                lb <= hdr[0];
                rb <= hdr[1];
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (accept && state == B0) hdr <= {bus.byte_in[7:4], bus.byte_in[1:0]};
        if (accept && state == B1) dxb <= bus.byte_in;
        if (accept && state == B2) dyb <= bus.byte_in;
    end
    assign bus.CursorX = cx;
    assign bus.CursorY = cy;
    assign bus.left_btn = lb;
    assign bus.right_btn = rb;
    assign bus.pkt_done = pd;
    assign bus.sync_err = se;
endmodule
